// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
//   Shared state types for the core's central sequencer.
//   fetch_state_t : imem handshake state (issue / wait / held / discard)
//   dmem_state_t  : dmem handshake state (idle / wait)
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    F_ISSUE,
    F_WAIT,
    F_HELD,
    F_DISCARD
  } fetch_state_t;

  typedef enum logic {
    M_IDLE,
    M_WAIT
  } dmem_state_t;

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// pipeline_ctrl_load_use_detect
//   Raw load-use comparator between the load in EX and the instruction in ID.
//   Masking by redirect / dmem stall is done by the caller.
//   Ports:
//     id_valid_i, id_rs1_i, id_rs2_i : decode-stage instruction and its sources
//     ex_valid_i, ex_mem_read_i      : EX holds a real load
//     ex_rd_i                        : EX destination register
//     hazard_o                       : unmasked load-use hazard
module pipeline_ctrl_load_use_detect (
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       ex_valid_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  output logic       hazard_o
);

  logic rd_nonzero;
  logic rd_match;

  assign rd_nonzero = (ex_rd_i != '0);
  assign rd_match   = (ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i);
  assign hazard_o   = id_valid_i && ex_valid_i && ex_mem_read_i && rd_nonzero && rd_match;

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Central sequencer for the 5-stage core. Owns the imem fetch handshake and
//   the dmem handshake, detects load-use hazards, applies EX redirects and
//   drives the load/flush enables of PC and all pipeline registers.
//   Ports:
//     clk, rst                      : clock, synchronous active-high reset
//     id_valid, id_rs1_s, id_rs2_s  : decode-stage instruction and sources
//     ex_valid, ex_mem_read, ex_rd_s: EX instruction, load flag, destination
//     ex_redirect                   : EX resolved a mispredict / jump
//     mem_access                    : MEM holds a valid load/store
//     imem_resp, dmem_resp          : memory responses
//     imem_issue, dmem_issue        : one-cycle memory requests
//     if_hold_we, if_use_hold       : IF 1-entry hold buffer control
//     pc_we, *_we, *_flush          : stage register load / bubble enables
//   All outputs are combinational from state and inputs.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs1_s,
  input  logic [4:0] id_rs2_s,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd_s,
  input  logic       ex_redirect,
  input  logic       mem_access,
  input  logic       imem_resp,
  input  logic       dmem_resp,
  output logic       imem_issue,
  output logic       dmem_issue,
  output logic       if_hold_we,
  output logic       if_use_hold,
  output logic       pc_we,
  output logic       if_id_we,
  output logic       if_id_flush,
  output logic       id_ex_we,
  output logic       id_ex_flush,
  output logic       ex_mem_we,
  output logic       mem_wb_we,
  output logic       mem_wb_flush
);

  fetch_state_t fetch_q, fetch_d;
  dmem_state_t  dmem_q,  dmem_d;

  logic lu_raw;
  logic dmem_stall;
  logic redir;
  logic lu;
  logic front_adv;
  logic deliver;
  logic issue;

  pipeline_ctrl_load_use_detect u_lu (
    .id_valid_i    (id_valid),
    .id_rs1_i      (id_rs1_s),
    .id_rs2_i      (id_rs2_s),
    .ex_valid_i    (ex_valid),
    .ex_mem_read_i (ex_mem_read),
    .ex_rd_i       (ex_rd_s),
    .hazard_o      (lu_raw)
  );

  assign dmem_stall = ((dmem_q == M_IDLE) && mem_access) || ((dmem_q == M_WAIT) && !dmem_resp);
  assign redir      = ex_redirect && ex_valid && !dmem_stall;
  assign lu         = lu_raw && !redir && !dmem_stall;
  assign front_adv  = !dmem_stall && !lu && !redir;

  always_comb begin
    fetch_d      = fetch_q;
    dmem_d       = dmem_q;
    deliver      = 1'b0;
    issue        = 1'b0;
    imem_issue   = 1'b0;
    dmem_issue   = 1'b0;
    if_hold_we   = 1'b0;
    if_use_hold  = 1'b0;
    pc_we        = 1'b0;
    if_id_we     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_we     = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_we    = 1'b0;
    mem_wb_we    = 1'b0;
    mem_wb_flush = 1'b0;

    unique case (dmem_q)
      M_IDLE: if (mem_access) begin
        dmem_issue = 1'b1;
        dmem_d     = M_WAIT;
      end
      M_WAIT: if (dmem_resp) dmem_d = M_IDLE;
      default: dmem_d = M_IDLE;
    endcase

    // A fetch is only issued on a cycle the PC may advance, so imem_issue and
    // pc_we always move together; a redirect loads the target into PC instead.
    unique case (fetch_q)
      F_ISSUE: if (front_adv) begin
        issue   = 1'b1;
        fetch_d = F_WAIT;
      end
      F_WAIT: begin
        if (imem_resp) begin
          if (redir) begin
            fetch_d = F_ISSUE;
          end else if (front_adv) begin
            deliver = 1'b1;
            issue   = 1'b1;
          end else begin
            if_hold_we = 1'b1;
            fetch_d    = F_HELD;
          end
        end else if (redir) begin
          fetch_d = F_DISCARD;
        end
      end
      F_HELD: begin
        if_use_hold = 1'b1;
        if (redir) begin
          fetch_d = F_ISSUE;
        end else if (front_adv) begin
          deliver = 1'b1;
          issue   = 1'b1;
          fetch_d = F_WAIT;
        end
      end
      F_DISCARD: if (imem_resp) begin
        // Stale data is dropped; if the PC cannot move this cycle the new
        // request is deferred to F_ISSUE rather than issued at a stale PC.
        if (front_adv) begin
          issue   = 1'b1;
          fetch_d = F_WAIT;
        end else begin
          fetch_d = F_ISSUE;
        end
      end
      default: fetch_d = F_ISSUE;
    endcase

    imem_issue = issue;

    if (dmem_stall) begin
      mem_wb_flush = 1'b1;
    end else if (redir) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      ex_mem_we   = 1'b1;
      mem_wb_we   = 1'b1;
      pc_we       = 1'b1;
    end else if (lu) begin
      id_ex_flush = 1'b1;
      ex_mem_we   = 1'b1;
      mem_wb_we   = 1'b1;
    end else begin
      id_ex_we    = 1'b1;
      ex_mem_we   = 1'b1;
      mem_wb_we   = 1'b1;
      if_id_we    = deliver;
      if_id_flush = !deliver;
      pc_we       = issue;
    end

    if (rst) begin
      imem_issue   = 1'b0;
      dmem_issue   = 1'b0;
      if_hold_we   = 1'b0;
      if_use_hold  = 1'b0;
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_we    = 1'b0;
      mem_wb_we    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) fetch_q <= F_ISSUE;
    else     fetch_q <= fetch_d;
  end

  always_ff @(posedge clk) begin
    if (rst) dmem_q <= M_IDLE;
    else     dmem_q <= dmem_d;
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1_s, id_rs2_s;
  logic       ex_valid, ex_mem_read;
  logic [4:0] ex_rd_s;
  logic       ex_redirect, mem_access, imem_resp, dmem_resp;
  logic       imem_issue, dmem_issue, if_hold_we, if_use_hold, pc_we;
  logic       if_id_we, if_id_flush, id_ex_we, id_ex_flush;
  logic       ex_mem_we, mem_wb_we, mem_wb_flush;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1_s     (id_rs1_s),
    .id_rs2_s     (id_rs2_s),
    .ex_valid     (ex_valid),
    .ex_mem_read  (ex_mem_read),
    .ex_rd_s      (ex_rd_s),
    .ex_redirect  (ex_redirect),
    .mem_access   (mem_access),
    .imem_resp    (imem_resp),
    .dmem_resp    (dmem_resp),
    .imem_issue   (imem_issue),
    .dmem_issue   (dmem_issue),
    .if_hold_we   (if_hold_we),
    .if_use_hold  (if_use_hold),
    .pc_we        (pc_we),
    .if_id_we     (if_id_we),
    .if_id_flush  (if_id_flush),
    .id_ex_we     (id_ex_we),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_we    (ex_mem_we),
    .mem_wb_we    (mem_wb_we),
    .mem_wb_flush (mem_wb_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector order:
  // {imem_issue, dmem_issue, if_hold_we, if_use_hold, pc_we,
  //  if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_we, mem_wb_flush}
  logic [11:0] dut_o;
  assign dut_o = {imem_issue, dmem_issue, if_hold_we, if_use_hold, pc_we,
                  if_id_we, if_id_flush, id_ex_we, id_ex_flush,
                  ex_mem_we, mem_wb_we, mem_wb_flush};

  // Reference model: tracks the fetch as "a request in flight", "that request
  // belongs to a squashed path" and "hold buffer occupied", plus "dmem busy".
  logic m_out, m_wrong, m_buf, m_dbusy;
  logic m_dstall, m_redir, m_lu, m_adv, m_got, m_deliver, m_issue, m_hold;
  logic [11:0] exp_o;

  always_comb begin
    m_dstall  = m_dbusy ? !dmem_resp : mem_access;
    m_redir   = ex_redirect && ex_valid && !m_dstall;
    m_lu      = id_valid && ex_valid && ex_mem_read && (ex_rd_s != 5'd0) &&
                (ex_rd_s == id_rs1_s || ex_rd_s == id_rs2_s) && !m_redir && !m_dstall;
    m_adv     = !m_dstall && !m_lu && !m_redir;
    m_got     = m_out && imem_resp;
    m_deliver = m_adv && (m_buf || (m_got && !m_wrong));
    m_issue   = m_adv && (!m_out || imem_resp);
    m_hold    = m_got && !m_wrong && !m_adv && !m_redir;
    exp_o = {m_issue,
             !m_dbusy && mem_access,
             m_hold,
             m_buf,
             m_issue || m_redir,
             m_deliver,
             m_redir || (m_adv && !m_deliver),
             m_adv,
             m_redir || m_lu,
             !m_dstall,
             !m_dstall,
             m_dstall};
    if (rst) exp_o = 12'b0000_0010_1001;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_out   <= 1'b0;
      m_wrong <= 1'b0;
      m_buf   <= 1'b0;
      m_dbusy <= 1'b0;
    end else begin
      m_dbusy <= m_dbusy ? !dmem_resp : mem_access;
      if (m_redir) begin
        m_buf   <= 1'b0;
        m_out   <= m_out && !imem_resp;
        m_wrong <= m_out && !imem_resp;
      end else begin
        m_buf   <= m_hold || (m_buf && !m_deliver);
        m_out   <= m_issue || (m_out && !imem_resp);
        m_wrong <= (m_out && !imem_resp) ? m_wrong : 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model plus the we/flush exclusivity rule.
  always @(negedge clk) begin
    n_checks++;
    if (dut_o !== exp_o) begin
      n_fail++;
      $display("FAIL cycle_model t=%0t: got %b expected %b", $time, dut_o, exp_o);
    end
    n_checks++;
    if ((if_id_we && if_id_flush) || (id_ex_we && id_ex_flush) || (mem_wb_we && mem_wb_flush)) begin
      n_fail++;
      $display("FAIL we_flush_exclusive t=%0t: got %b expected no register with both set", $time, dut_o);
    end
  end

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Check DUT and model against a hand-derived vector, then advance one cycle.
  task automatic cyc(input string name, input logic [11:0] e);
    @(negedge clk);
    check(name, dut_o, e);
    check({"model_", name}, exp_o, e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_rs1_s = 0; id_rs2_s = 0;
    ex_valid = 0; ex_mem_read = 0; ex_rd_s = 0; ex_redirect = 0;
    mem_access = 0; imem_resp = 0; dmem_resp = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    for (int i = 0; i < 3; i++) cyc("reset", 12'b0000_0010_1001);
    rst = 0;
    cyc("first_issue", 12'b1000_1011_0110);
    imem_resp = 1;
    cyc("fetch_deliver", 12'b1000_1101_0110);

    // load-use: lw x5 in EX, add rs1=x5 in ID
    imem_resp = 0; id_valid = 1; id_rs1_s = 5;
    ex_valid = 1; ex_mem_read = 1; ex_rd_s = 5;
    cyc("load_use_bubble", 12'b0000_0000_1110);
    ex_valid = 0; ex_mem_read = 0;
    cyc("load_use_release", 12'b0000_0011_0110);

    // fetch response during load-use goes to the hold buffer
    ex_valid = 1; ex_mem_read = 1; imem_resp = 1;
    cyc("hold_capture", 12'b0010_0000_1110);
    ex_valid = 0; ex_mem_read = 0; imem_resp = 0;
    cyc("hold_deliver", 12'b1001_1101_0110);

    // dmem access answered three cycles after issue
    id_valid = 0; id_rs1_s = 0; mem_access = 1;
    cyc("dmem_issue", 12'b0100_0000_0001);
    cyc("dmem_wait1", 12'b0000_0000_0001);
    cyc("dmem_wait2", 12'b0000_0000_0001);
    dmem_resp = 1;
    cyc("dmem_resp", 12'b0000_0011_0110);
    mem_access = 0; dmem_resp = 0;

    // redirect while a fetch is outstanding; its response is discarded
    ex_valid = 1; ex_redirect = 1;
    cyc("redir_wait", 12'b0000_1010_1110);
    ex_valid = 0; ex_redirect = 0;
    cyc("discard_wait", 12'b0000_0011_0110);
    imem_resp = 1;
    cyc("discard_resp", 12'b1000_1011_0110);
    imem_resp = 0;

    // redirect held off by a dmem stall, applied on the response cycle
    mem_access = 1; ex_valid = 1; ex_redirect = 1;
    cyc("redir_dmem_issue", 12'b0100_0000_0001);
    cyc("redir_dmem_wait", 12'b0000_0000_0001);
    dmem_resp = 1;
    cyc("redir_dmem_release", 12'b0000_1010_1110);
    idle_inputs();
    imem_resp = 1;
    cyc("redir_dmem_refetch", 12'b1000_1011_0110);

    // randomized traffic checked against the model every cycle
    for (int n = 0; n < 4000; n++) begin
      rst         = ($urandom_range(199) == 0);
      id_valid    = ($urandom_range(3) != 0);
      id_rs1_s    = 5'($urandom_range(3));
      id_rs2_s    = 5'($urandom_range(3));
      ex_valid    = ($urandom_range(3) != 0);
      ex_mem_read = ($urandom_range(2) == 0);
      ex_rd_s     = 5'($urandom_range(3));
      ex_redirect = ($urandom_range(7) == 0);
      mem_access  = ($urandom_range(3) == 0);
      imem_resp   = ($urandom_range(1) == 0);
      dmem_resp   = ($urandom_range(2) == 0);
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
